// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply blocks: FSM state encoding,
// a constant-evaluable clog2 and the flattened-bus element offset helper.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // LSB position of element (r,col) in a row-major rows x cols matrix whose
    // element [0][0] sits in the most-significant slot.
    function automatic int elem_lsb(input int r, input int col, input int rows,
                                    input int cols, input int ew);
        return (rows * cols - 1 - (r * cols + col)) * ew;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_mac.sv
// Shared unsigned multiply-accumulate unit. The accumulator is wide enough
// to hold the sum of K_DIM full-width products without wrapping.
module matmul_seq_ctrl_mac #(
    parameter int EW = 8,
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] acc
);

    logic [2*EW-1:0] prod_s;
    logic [AW-1:0]   acc_r;

    // Full-width unsigned product of the current operand pair.
    always_comb begin
        prod_s = {{EW{1'b0}}, a} * {{EW{1'b0}}, b};
    end

    // Accumulator: clear has priority over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= acc_r + AW'(prod_s);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequential C = A x B using one shared MAC, one multiply-accumulate per
// cycle, with a start/busy/done handshake. Operands are latched in LOAD so
// the host may change the input buses while a product is in flight.
// Optional build macro MATMUL_SAT_EN: saturate each C element at 2^EW-1 and
// expose a sticky sat_flag output.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int A_ROWS = 3,
    parameter int K_DIM  = 2,
    parameter int B_COLS = 6,
    parameter int EW     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [A_ROWS*K_DIM*EW-1:0]   a_in,
    input  logic [K_DIM*B_COLS*EW-1:0]   b_in,
    output logic                         busy,
    output logic                         done,
    output logic [A_ROWS*B_COLS*EW-1:0]  c_out
`ifdef MATMUL_SAT_EN
    ,
    output logic                         sat_flag
`endif
);

    localparam int AW  = 2 * EW + clog2(K_DIM);
    localparam int IW  = (clog2(A_ROWS) > 0) ? clog2(A_ROWS) : 1;
    localparam int JW  = (clog2(B_COLS) > 0) ? clog2(B_COLS) : 1;
    localparam int KW  = (clog2(K_DIM)  > 0) ? clog2(K_DIM)  : 1;
    localparam int AOW = clog2(A_ROWS * K_DIM * EW);
    localparam int BOW = clog2(K_DIM * B_COLS * EW);
    localparam int COW = clog2(A_ROWS * B_COLS * EW);

    state_t                        state_r;
    state_t                        next_s;
    logic [A_ROWS*K_DIM*EW-1:0]    a_lat_r;
    logic [K_DIM*B_COLS*EW-1:0]    b_lat_r;
    logic [A_ROWS*B_COLS*EW-1:0]   c_r;
    logic [IW-1:0]                 i_r;
    logic [JW-1:0]                 j_r;
    logic [KW-1:0]                 k_r;
    logic                          busy_r;
    logic                          done_r;
    logic                          last_s;
    logic                          mac_clr_s;
    logic                          mac_en_s;
    logic [AOW-1:0]                a_off_s;
    logic [BOW-1:0]                b_off_s;
    logic [COW-1:0]                c_off_s;
    logic [EW-1:0]                 op_a_s;
    logic [EW-1:0]                 op_b_s;
    logic [AW-1:0]                 acc_s;
    logic [EW-1:0]                 res_s;
`ifdef MATMUL_SAT_EN
    logic                          ovf_s;
    logic                          sat_r;
`endif

    // Single shared multiply-accumulate unit.
    matmul_seq_ctrl_mac #(
        .EW (EW),
        .AW (AW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (op_a_s),
        .b     (op_b_s),
        .clr   (mac_clr_s),
        .en    (mac_en_s),
        .acc   (acc_s)
    );

    // Operand selection, write-back position and element result.
    always_comb begin
        last_s    = (i_r == IW'(A_ROWS - 1)) && (j_r == JW'(B_COLS - 1));
        mac_clr_s = (state_r == ST_LOAD) || (state_r == ST_WRITE);
        mac_en_s  = (state_r == ST_MAC);
        a_off_s   = AOW'(elem_lsb(int'(i_r), int'(k_r), A_ROWS, K_DIM, EW));
        b_off_s   = BOW'(elem_lsb(int'(k_r), int'(j_r), K_DIM, B_COLS, EW));
        c_off_s   = COW'(elem_lsb(int'(i_r), int'(j_r), A_ROWS, B_COLS, EW));
        op_a_s    = a_lat_r[a_off_s +: EW];
        op_b_s    = b_lat_r[b_off_s +: EW];
`ifdef MATMUL_SAT_EN
        ovf_s     = |acc_s[AW-1:EW];
        if (ovf_s) begin
            res_s = {EW{1'b1}};
        end else begin
            res_s = acc_s[EW-1:0];
        end
`else
        res_s     = EW'(acc_s);
`endif
    end

    // Next-state logic for the IDLE/LOAD/MAC/WRITE/DONE sequence.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = ST_LOAD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_LOAD: next_s = ST_MAC;
            ST_MAC: begin
                if (k_r == KW'(K_DIM - 1)) begin
                    next_s = ST_WRITE;
                end else begin
                    next_s = ST_MAC;
                end
            end
            ST_WRITE: begin
                if (last_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_MAC;
                end
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Registered handshake outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_s == ST_LOAD) || (next_s == ST_MAC) || (next_s == ST_WRITE);
            done_r <= (next_s == ST_DONE);
        end
    end

    // Operand latches, index counters and C write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat_r <= '0;
            b_lat_r <= '0;
            c_r     <= '0;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    a_lat_r <= a_in;
                    b_lat_r <= b_in;
                    c_r     <= '0;
                    i_r     <= '0;
                    j_r     <= '0;
                    k_r     <= '0;
                end
                ST_MAC: begin
                    if (k_r != KW'(K_DIM - 1)) begin
                        k_r <= k_r + KW'(1);
                    end else begin
                        k_r <= k_r;
                    end
                end
                ST_WRITE: begin
                    c_r[c_off_s +: EW] <= res_s;
                    k_r                <= '0;
                    if (j_r == JW'(B_COLS - 1)) begin
                        j_r <= '0;
                        i_r <= i_r + IW'(1);
                    end else begin
                        j_r <= j_r + JW'(1);
                    end
                end
                default: begin
                    c_r <= c_r;
                end
            endcase
        end
    end

`ifdef MATMUL_SAT_EN
    // Sticky saturation flag for the product in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= 1'b0;
        end else if (state_r == ST_LOAD) begin
            sat_r <= 1'b0;
        end else if ((state_r == ST_WRITE) && ovf_s) begin
            sat_r <= 1'b1;
        end else begin
            sat_r <= sat_r;
        end
    end

    assign sat_flag = sat_r;
`endif

    assign busy  = busy_r;
    assign done  = done_r;
    assign c_out = c_r;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: directed test-plan vectors plus
// randomized products against an arithmetic reference model.
module tb_matmul_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         start2 = 1'b0;
    logic [47:0]  a_in = 48'd0;
    logic [95:0]  b_in = 96'd0;
    logic         busy, done;
    logic [143:0] c_out;
    logic [15:0]  a2 = 16'd0;
    logic [15:0]  b2 = 16'd0;
    logic         busy2, done2;
    logic [31:0]  c2;
`ifdef MATMUL_SAT_EN
    logic         sat_flag;
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int           n_checks = 0;
    int           n_fail = 0;
    bit           sel = 1'b0;
    logic         cur_busy, cur_done;
    logic [143:0] cur_c;

    always #5 clk = ~clk;

    matmul_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .c_out (c_out)
`ifdef MATMUL_SAT_EN
        ,
        .sat_flag (sat_flag)
`endif
    );

    matmul_seq_ctrl #(.A_ROWS(2), .K_DIM(1), .B_COLS(2), .EW(8)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a_in  (a2),
        .b_in  (b2),
        .busy  (busy2),
        .done  (done2),
        .c_out (c2)
`ifdef MATMUL_SAT_EN
        ,
        .sat_flag ()
`endif
    );

    always_comb begin
        cur_busy = sel ? busy2 : busy;
        cur_done = sel ? done2 : done;
        cur_c    = sel ? {112'd0, c2} : c_out;
    end

    task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Element idx (row-major, 0 = most-significant byte) of a flattened matrix.
    function automatic int el(input logic [143:0] v, input int idx, input int total);
        logic [143:0] t;
        t = (v >> ((total - 1 - idx) * 8)) & 144'hFF;
        return int'(t[7:0]);
    endfunction

    function automatic logic [143:0] model_c(input logic [143:0] a, input logic [143:0] b,
                                             input int ar, input int kd, input int bc);
        logic [143:0] c;
        c = 144'd0;
        for (int r = 0; r < ar; r++) begin
            for (int col = 0; col < bc; col++) begin
                int s;
                int v;
                s = 0;
                for (int k = 0; k < kd; k++)
                    s += el(a, r * kd + k, ar * kd) * el(b, k * bc + col, kd * bc);
                if (SAT) v = (s > 255) ? 255 : s;
                else     v = s % 256;
                c |= 144'(v) << ((ar * bc - 1 - (r * bc + col)) * 8);
            end
        end
        return c;
    endfunction

    function automatic bit model_sat(input logic [143:0] a, input logic [143:0] b,
                                     input int ar, input int kd, input int bc);
        bit any;
        any = 1'b0;
        for (int r = 0; r < ar; r++)
            for (int col = 0; col < bc; col++) begin
                int s;
                s = 0;
                for (int k = 0; k < kd; k++)
                    s += el(a, r * kd + k, ar * kd) * el(b, k * bc + col, kd * bc);
                if (s > 255) any = 1'b1;
            end
        return any;
    endfunction

    // mode 0: plain product; mode 1: extra start pulses and input changes mid-run.
    task automatic run_prod(input bit use2, input logic [143:0] a_raw, input logic [143:0] b_raw,
                            input int ar, input int kd, input int bc, input int mode,
                            input string tag);
        logic [143:0] a, b, exp;
        int lat, edges, busy_cnt, w;
        a = a_raw & ((144'd1 << (ar * kd * 8)) - 144'd1);
        b = b_raw & ((144'd1 << (kd * bc * 8)) - 144'd1);
        exp = model_c(a, b, ar, kd, bc);
        // edges from the start-sampling edge to the edge after which done is high
        lat = 1 + ar * bc * (kd + 1);
        sel = use2;
        @(negedge clk);
        w = 0;
        while ((cur_busy || cur_done) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (use2) begin
            a2 = a[15:0]; b2 = b[15:0]; start2 = 1'b1;
        end else begin
            a_in = a[47:0]; b_in = b[95:0]; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        edges = 0;
        busy_cnt = 0;
        while (!cur_done && edges < lat + 20) begin
            if (cur_busy) busy_cnt++;
            if (mode == 1 && edges == 5) begin
                a_in = ~a_in;
                b_in = ~b_in;
            end
            if (mode == 1 && edges == 10) start = 1'b1;
            if (mode == 1 && edges == 11) start = 1'b0;
            @(posedge clk); #1;
            edges++;
            if (edges == 1) check_eq({tag, "_c_cleared_in_load"}, cur_c, 144'd0);
        end
        check_eq({tag, "_latency"}, 144'(edges), 144'(lat));
        check_eq({tag, "_busy_cycles"}, 144'(busy_cnt), 144'(lat));
        check_eq({tag, "_c_out"}, cur_c, exp);
`ifdef MATMUL_SAT_EN
        if (!use2) check_eq({tag, "_sat_flag"}, 144'(sat_flag), 144'(model_sat(a, b, ar, kd, bc)));
`endif
        if (mode == 1) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_done_single_pulse"}, 144'(cur_done), 144'd0);
        check_eq({tag, "_idle_after_done"}, 144'(cur_busy), 144'd0);
        if (mode == 1) begin
            repeat (3) @(posedge clk);
            #1;
            check_eq({tag, "_no_second_op"}, 144'(cur_busy), 144'd0);
            check_eq({tag, "_c_held"}, cur_c, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [143:0] a, b;
        #1;
        check_eq("reset_busy", 144'(busy), 144'd0);
        check_eq("reset_done", 144'(done), 144'd0);
        check_eq("reset_c_out", c_out, 144'd0);
`ifdef MATMUL_SAT_EN
        check_eq("reset_sat_flag", 144'(sat_flag), 144'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Functional product from the test plan.
        a = 144'h01_00_01_01_00_01;
        b = 144'h01_00_01_00_01_00_01_00_01_01_00_01;
        run_prod(1'b0, a, b, 3, 2, 6, 0, "func");
        check_eq("func_const", c_out, 144'h01_00_01_00_01_00_02_00_02_01_01_01_01_00_01_01_00_01);

        // Back-to-back: started in the first IDLE cycle after done.
        run_prod(1'b0, 144'h01_00_00_01_00_00, b, 3, 2, 6, 0, "b2b");
        check_eq("b2b_const", c_out, 144'h01_00_01_00_01_00_01_00_01_01_00_01_00_00_00_00_00_00);

        // Overflow: all elements 255.
        run_prod(1'b0, {18{8'hFF}}, {18{8'hFF}}, 3, 2, 6, 0, "ovf");
        check_eq("ovf_const", c_out, SAT ? {18{8'hFF}} : {18{8'h02}});

        // Ignored starts and operand isolation.
        run_prod(1'b0, {$urandom, $urandom}, {$urandom, $urandom, $urandom}, 3, 2, 6, 1, "iso");

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a_in = 48'h05_07_09_0B_0D_0F;
        b_in = 96'h11_22_33_44_55_66_77_88_99_AA_BB_CC;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 144'(busy), 144'd0);
        check_eq("rst_mid_done", 144'(done), 144'd0);
        check_eq("rst_mid_c_out", c_out, 144'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_prod(1'b0, {96'd0, a_in}, {48'd0, b_in}, 3, 2, 6, 0, "after_rst");

        // Randomized products.
        for (int n = 0; n < 4; n++)
            run_prod(1'b0, {$urandom, $urandom}, {$urandom, $urandom, $urandom}, 3, 2, 6, 0, "rand");

        // Parameter sweep: 2x1 times 1x2.
        run_prod(1'b1, 144'h03_04, 144'h05_06, 2, 1, 2, 0, "sweep");
        check_eq("sweep_const", {112'd0, c2}, 144'h0F_12_14_18);
        for (int n = 0; n < 3; n++)
            run_prod(1'b1, 144'($urandom), 144'($urandom), 2, 1, 2, 0, "sweep_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
